// File: rtl/blake2_msg_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : blake2_msg_sequencer_if
//  Brief    : Host-side and core-side signal bundle for blake2_msg_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface blake2_msg_sequencer_if #(
  parameter int BLOCK_BITS       = 1024,
  parameter int LENGTH_BITS      = 128,
  parameter int DIGEST_BITS      = 88,
  parameter int CORE_DIGEST_BITS = 512
);
  // Host side; the final-block strobe is final_blk because "final" is reserved.
  logic                        init;
  logic                        next;
  logic                        final_blk;
  logic [BLOCK_BITS-1:0]       block;
  logic [LENGTH_BITS-1:0]      length;
  logic                        ready;
  logic                        digest_valid;
  logic [DIGEST_BITS-1:0]      digest;
  logic                        err;

  // Compression-core side
  logic                        core_init;
  logic                        core_next;
  logic                        core_final;
  logic [BLOCK_BITS-1:0]       core_block;
  logic [LENGTH_BITS-1:0]      core_length;
  logic                        core_ready;
  logic                        core_digest_valid;
  logic [CORE_DIGEST_BITS-1:0] core_digest;

  modport slave (
    input  init, next, final_blk, block, length,
    input  core_ready, core_digest_valid, core_digest,
    output ready, digest_valid, digest, err,
    output core_init, core_next, core_final, core_block, core_length
  );

  modport master (
    output init, next, final_blk, block, length,
    output core_ready, core_digest_valid, core_digest,
    input  ready, digest_valid, digest, err,
    input  core_init, core_next, core_final, core_block, core_length
  );
endinterface
`default_nettype wire

// File: rtl/blake2_msg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : blake2_msg_sequencer
//  Brief    : Buffers up to DEPTH message blocks from the host, replays them
//             to a BLAKE2 core as init/next/final commands, holds the digest.
//  Revision : 1.0  initial release
// ============================================================================
module blake2_msg_sequencer #(
  parameter int BLOCK_BITS       = 1024,
  parameter int DEPTH            = 8,
  parameter int DIGEST_BITS      = 88,
  parameter int CORE_DIGEST_BITS = 512,
  parameter int LENGTH_BITS      = 128
) (
  input  wire logic             clk,
  input  wire logic             rst,
  blake2_msg_sequencer_if.slave bus
);

  // Counter width covers the command index, which runs to count+1.
  localparam int CW = $clog2(DEPTH + 2);

  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] c_ONE   = CW'(1);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_COLLECT   = 3'd1;
  localparam logic [2:0] c_ISSUE     = 3'd2;
  localparam logic [2:0] c_GAP       = 3'd3;
  localparam logic [2:0] c_WAIT_DGST = 3'd4;
  localparam logic [2:0] c_DONE      = 3'd5;

  logic [BLOCK_BITS-1:0]  r_mem [DEPTH];
  logic [2:0]             r_state;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          r_rd_idx;
  logic [LENGTH_BITS-1:0] r_length;
  logic                   r_err;
  logic                   r_digest_valid;
  logic [DIGEST_BITS-1:0] r_digest;

  logic                   w_accept;
  logic                   w_busy;
  logic                   w_host_cmd;
  logic                   w_append;
  logic                   w_full;
  logic                   w_wr_en;
  logic [CW-1:0]          w_wr_idx;
  logic                   w_fire;
  logic                   w_cmd_init;
  logic                   w_cmd_final;
  logic                   w_cmd_next;
  logic [CW-1:0]          w_rd_m1;
  logic [BLOCK_BITS-1:0]  w_rd_block;

  assign w_accept   = (r_state == c_IDLE) || (r_state == c_COLLECT) || (r_state == c_DONE);
  assign w_busy     = (r_state == c_ISSUE) || (r_state == c_GAP) || (r_state == c_WAIT_DGST);
  assign w_host_cmd = bus.init | bus.next | bus.final_blk;
  assign w_append   = bus.next | bus.final_blk;
  assign w_full     = (r_count == c_DEPTH);

  // init always lands in slot 0; appends go to the next free slot unless full.
  assign w_wr_idx = bus.init ? '0 : r_count;
  assign w_wr_en  = (w_accept && bus.init) ||
                    ((r_state == c_COLLECT) && w_append && !w_full);

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_en && (w_wr_idx == CW'(i))) begin
        r_mem[i] <= bus.block;
      end
    end
  end

  // Command index 0 is the core_init; index n>0 replays slot n-1.
  assign w_rd_m1 = r_rd_idx - c_ONE;

  always_comb begin
    w_rd_block = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rd_m1 == CW'(i)) begin
        w_rd_block = r_mem[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= c_IDLE;
      r_count        <= '0;
      r_rd_idx       <= '0;
      r_length       <= '0;
      r_err          <= 1'b0;
      r_digest_valid <= 1'b0;
      r_digest       <= '0;
    end else begin
      case (r_state)
        c_IDLE, c_COLLECT, c_DONE: begin
          if (bus.init) begin
            r_count        <= c_ONE;
            r_rd_idx       <= '0;
            r_err          <= 1'b0;
            r_digest_valid <= 1'b0;
            r_digest       <= '0;
            if (bus.final_blk) begin
              r_length <= bus.length;
              r_state  <= c_ISSUE;
            end else begin
              r_state  <= c_COLLECT;
            end
          end else if (w_append) begin
            if (r_state != c_COLLECT) begin
              r_err <= 1'b1;
            end else if (w_full) begin
              // Overflow abandons the message; nothing goes to the core.
              r_err   <= 1'b1;
              r_state <= c_IDLE;
            end else begin
              r_count <= r_count + c_ONE;
              if (bus.final_blk) begin
                r_length <= bus.length;
                r_rd_idx <= '0;
                r_state  <= c_ISSUE;
              end
            end
          end
        end

        c_ISSUE: begin
          if (bus.core_ready) begin
            r_rd_idx <= r_rd_idx + c_ONE;
            r_state  <= c_GAP;
          end
        end

        c_GAP: begin
          r_state <= (r_rd_idx > r_count) ? c_WAIT_DGST : c_ISSUE;
        end

        c_WAIT_DGST: begin
          if (bus.core_digest_valid) begin
            r_digest       <= bus.core_digest[DIGEST_BITS-1:0];
            r_digest_valid <= 1'b1;
            r_state        <= c_DONE;
          end
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase

      if (w_busy && w_host_cmd) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_fire      = (r_state == c_ISSUE) && bus.core_ready;
  assign w_cmd_init  = w_fire && (r_rd_idx == '0);
  assign w_cmd_final = w_fire && (r_rd_idx == r_count);
  assign w_cmd_next  = w_fire && (r_rd_idx != '0) && (r_rd_idx != r_count);

  assign bus.core_init    = w_cmd_init;
  assign bus.core_next    = w_cmd_next;
  assign bus.core_final   = w_cmd_final;
  assign bus.core_block   = (w_cmd_next || w_cmd_final) ? w_rd_block : '0;
  assign bus.core_length  = w_cmd_final ? r_length : '0;

  assign bus.ready        = (r_state == c_IDLE) || (r_state == c_DONE) ||
                            ((r_state == c_COLLECT) && !w_full);
  assign bus.digest_valid = r_digest_valid;
  assign bus.digest       = r_digest;
  assign bus.err          = r_err;

  generate
    if (CORE_DIGEST_BITS > DIGEST_BITS) begin : g_dig_trunc
      logic w_unused_dig_hi;
      assign w_unused_dig_hi = ^bus.core_digest[CORE_DIGEST_BITS-1:DIGEST_BITS];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_blake2_msg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blake2_msg_sequencer
//  Brief    : Randomised scoreboard bench with a message-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_blake2_msg_sequencer;
  localparam int BB    = 1024;
  localparam int DEPTH = 8;
  localparam int DB    = 88;
  localparam int CDB   = 512;
  localparam int LB    = 128;

  typedef struct {
    int            kind;   // 0 init, 1 next, 2 final
    logic [BB-1:0] blk;
    logic [LB-1:0] len;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  blake2_msg_sequencer_if #(.BLOCK_BITS(BB), .LENGTH_BITS(LB),
                            .DIGEST_BITS(DB), .CORE_DIGEST_BITS(CDB)) bus ();

  blake2_msg_sequencer #(.BLOCK_BITS(BB), .DEPTH(DEPTH), .DIGEST_BITS(DB),
                         .CORE_DIGEST_BITS(CDB), .LENGTH_BITS(LB))
    dut (.clk(clk), .rst(rst), .bus(bus));

  cmd_t          exp_cmd[$];
  logic [DB-1:0] exp_dig[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_cmds = 0;
  int n_final = 0;
  int last_cmd_cyc = -10;
  int init_cyc = 0;
  int final_cyc = 0;
  int dig_cyc = 0;
  int host_cyc = 0;
  int ready_mode = 0;   // 0 ready, 1 stalled, 2 random
  logic [DB-1:0] cur_dig = '0;
  logic prev_dv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BB-1:0] rnd_blk();
    logic [BB-1:0] r;
    for (int w = 0; w < BB / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: a k-block message becomes init, k-1 nexts, one final.
  task automatic push_expected(input logic [BB-1:0] blks[$], input logic [LB-1:0] len);
    cmd_t c;
    c.kind = 0; c.blk = '0; c.len = '0;
    exp_cmd.push_back(c);
    for (int i = 0; i < blks.size(); i++) begin
      c.kind = (i == blks.size() - 1) ? 2 : 1;
      c.blk  = blks[i];
      c.len  = (c.kind == 2) ? len : '0;
      exp_cmd.push_back(c);
    end
  endtask

  task automatic host(input bit i, input bit n, input bit f, input logic [BB-1:0] b, input logic [LB-1:0] l);
    bus.init = i; bus.next = n; bus.final_blk = f; bus.block = b; bus.length = l;
    @(posedge clk); #1;
    host_cyc = cyc;
    bus.init = 0; bus.next = 0; bus.final_blk = 0; bus.block = '0; bus.length = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_digest();
    int t = 0;
    while (!bus.digest_valid && t < 400) begin @(negedge clk); t++; end
    chk(t < 400, "digest_timeout", 128'(t), 128'(400));
    @(posedge clk); #1;
  endtask

  task automatic send_msg(input logic [BB-1:0] blks[$], input logic [LB-1:0] len, input int max_gap);
    if (blks.size() == 1) begin
      push_expected(blks, len);
      host(1, 0, 1, blks[0], len);
    end else begin
      host(1, 0, 0, blks[0], '0);
      for (int i = 1; i < blks.size(); i++) begin
        idle($urandom_range(0, max_gap));
        if (i == blks.size() - 1) begin
          push_expected(blks, len);
          host(0, 0, 1, blks[i], len);
        end else begin
          host(0, 1, 0, blks[i], '0);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk(bus.ready == 1'b1,        {tag, "_ready"},  128'(bus.ready), 128'(1));
    chk(bus.digest_valid == 1'b0, {tag, "_dvalid"}, 128'(bus.digest_valid), 128'(0));
    chk(bus.digest == '0,         {tag, "_digest"}, 128'(bus.digest), 128'(0));
    chk(bus.err == 1'b0,          {tag, "_err"},    128'(bus.err), 128'(0));
    chk({bus.core_init, bus.core_next, bus.core_final} == 3'b000, {tag, "_cmds"},
        128'({bus.core_init, bus.core_next, bus.core_final}), 128'(0));
    chk(bus.core_block == '0 && bus.core_length == '0, {tag, "_core_data"},
        bus.core_block[127:0], bus.core_length);
  endtask

  // Monitor: command scoreboard, spacing and digest checks.
  always @(negedge clk) begin
    int   nc;
    int   kind;
    cmd_t e;
    if (rst) begin
      prev_dv = 1'b0;
    end else begin
      nc = int'(bus.core_init) + int'(bus.core_next) + int'(bus.core_final);
      if (nc != 0) begin
        kind = bus.core_init ? 0 : (bus.core_next ? 1 : 2);
        chk(nc == 1, "cmd_onehot", 128'(nc), 128'(1));
        chk(cyc - last_cmd_cyc >= 2, "cmd_spacing", 128'(cyc - last_cmd_cyc), 128'(2));
        last_cmd_cyc = cyc;
        n_cmds++;
        if (kind == 0) init_cyc = cyc;
        if (kind == 2) begin final_cyc = cyc; n_final++; end
        if (exp_cmd.size() == 0) begin
          chk(1'b0, "unexpected_cmd", 128'(kind), 128'(99));
        end else begin
          e = exp_cmd.pop_front();
          chk(kind == e.kind, "cmd_kind", 128'(kind), 128'(e.kind));
          chk(bus.core_block == e.blk, "cmd_block", bus.core_block[127:0], e.blk[127:0]);
          chk(bus.core_length == e.len, "cmd_length", bus.core_length, e.len);
        end
      end else begin
        chk(bus.core_block == '0 && bus.core_length == '0, "idle_core_data",
            bus.core_block[127:0], bus.core_length);
      end

      if (bus.digest_valid && !prev_dv) begin
        chk(cyc == dig_cyc + 1, "digest_latency", 128'(cyc), 128'(dig_cyc + 1));
        if (exp_dig.size() == 0) begin
          chk(1'b0, "unexpected_digest", 128'(bus.digest), 128'(0));
        end else begin
          cur_dig = exp_dig.pop_front();
          chk(bus.digest == cur_dig, "digest", 128'(bus.digest), 128'(cur_dig));
        end
      end else if (bus.digest_valid) begin
        chk(bus.digest == cur_dig, "digest_hold", 128'(bus.digest), 128'(cur_dig));
      end
      prev_dv = bus.digest_valid;
    end
  end

  // Core model: ready pattern, digest a few cycles after each final, junk pulses otherwise.
  initial begin
    int dig_cnt = 0;
    int handled = 0;
    logic [CDB-1:0] d;
    bus.core_ready = 1'b1;
    bus.core_digest_valid = 1'b0;
    bus.core_digest = '0;
    forever begin
      @(posedge clk); #2;
      bus.core_digest_valid = 1'b0;
      case (ready_mode)
        0:       bus.core_ready = 1'b1;
        1:       bus.core_ready = 1'b0;
        default: bus.core_ready = ($urandom_range(0, 3) != 0);
      endcase
      for (int w = 0; w < CDB / 32; w++) d[w*32 +: 32] = $urandom;
      if (rst) begin
        dig_cnt = 0;
        handled = n_final;
      end else if (dig_cnt > 0) begin
        dig_cnt--;
        if (dig_cnt == 0) begin
          bus.core_digest = d;
          bus.core_digest_valid = 1'b1;
          exp_dig.push_back(d[DB-1:0]);
          dig_cyc = cyc;
        end
      end else if (handled != n_final) begin
        handled = n_final;
        dig_cnt = $urandom_range(1, 5);
      end else if ($urandom_range(0, 11) == 0) begin
        bus.core_digest = d;
        bus.core_digest_valid = 1'b1;
      end
    end
  end

  initial begin
    logic [BB-1:0] q[$];
    logic [BB-1:0] b;
    int n0;
    int rel_cyc;
    int k;

    bus.init = 0; bus.next = 0; bus.final_blk = 0; bus.block = '0; bus.length = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // Single block "abc", length 3
    b = '0; b[23:0] = 24'h636261;
    q = {b};
    send_msg(q, 128'd3, 0);
    n0 = host_cyc;
    wait_digest();
    chk(init_cyc == n0, "single_init_latency", 128'(init_cyc), 128'(n0));
    chk(final_cyc == init_cyc + 2, "single_final_spacing", 128'(final_cyc - init_cyc), 128'(2));
    chk(bus.err == 1'b0, "single_err", 128'(bus.err), 128'(0));

    // Three blocks, length 300
    q = {rnd_blk(), rnd_blk(), rnd_blk()};
    send_msg(q, 128'd300, 0);
    wait_digest();
    chk(final_cyc - init_cyc == 6, "three_cmd_span", 128'(final_cyc - init_cyc), 128'(6));
    chk(exp_cmd.size() == 0, "three_drained", 128'(exp_cmd.size()), 128'(0));

    // Overflow: fill DEPTH slots, then one more next
    host(1, 0, 0, rnd_blk(), '0);
    for (int i = 1; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        @(negedge clk);
        chk(bus.ready == 1'b1, "ovf_ready_not_full", 128'(bus.ready), 128'(1));
        @(posedge clk); #1;
      end
      host(0, 1, 0, rnd_blk(), '0);
    end
    @(negedge clk);
    chk(bus.ready == 1'b0, "ovf_ready_full", 128'(bus.ready), 128'(0));
    @(posedge clk); #1;
    n0 = n_cmds;
    host(0, 1, 0, rnd_blk(), '0);
    idle(6);
    chk(bus.err == 1'b1, "ovf_err", 128'(bus.err), 128'(1));
    chk(bus.ready == 1'b1, "ovf_idle_ready", 128'(bus.ready), 128'(1));
    chk(n_cmds == n0, "ovf_no_cmds", 128'(n_cmds), 128'(n0));
    q = {rnd_blk(), rnd_blk()};
    host(1, 0, 0, q[0], '0);
    chk(bus.err == 1'b0, "ovf_init_clears_err", 128'(bus.err), 128'(0));
    push_expected(q, 128'd100);
    host(0, 0, 1, q[1], 128'd100);
    wait_digest();

    // Restart: A's blocks must never reach the core
    host(1, 0, 0, rnd_blk(), '0);
    host(0, 1, 0, rnd_blk(), '0);
    q = {rnd_blk(), rnd_blk()};
    host(1, 0, 0, q[0], '0);
    push_expected(q, 128'd200);
    host(0, 0, 1, q[1], 128'd200);
    wait_digest();
    chk(bus.err == 1'b0, "restart_err", 128'(bus.err), 128'(0));

    // Stall: core_ready low for 10 cycles after final, host next meanwhile
    ready_mode = 1;
    q = {rnd_blk(), rnd_blk()};
    send_msg(q, 128'd77, 0);
    n0 = n_cmds;
    idle(3);
    host(0, 1, 0, rnd_blk(), '0);
    idle(6);
    chk(n_cmds == n0, "stall_no_cmds", 128'(n_cmds), 128'(n0));
    chk(bus.err == 1'b1, "stall_host_err", 128'(bus.err), 128'(1));
    ready_mode = 0;
    rel_cyc = cyc;
    wait_digest();
    chk(init_cyc == rel_cyc, "stall_release_init", 128'(init_cyc), 128'(rel_cyc));
    chk(bus.err == 1'b1, "stall_err_sticky", 128'(bus.err), 128'(1));

    // Reset during the GAP after the first core_next of a 4-block message
    q = {rnd_blk(), rnd_blk(), rnd_blk(), rnd_blk()};
    n0 = n_cmds;
    send_msg(q, 128'd500, 0);
    idle(3);
    rst = 1'b1;
    exp_cmd.delete();
    exp_dig.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    chk(n_cmds == n0 + 2, "midrst_cmds_seen", 128'(n_cmds), 128'(n0 + 2));
    @(posedge clk); #1;
    q = {rnd_blk()};
    send_msg(q, 128'd64, 0);
    wait_digest();
    chk(bus.err == 1'b0, "midrst_fresh_err", 128'(bus.err), 128'(0));

    // Randomised messages with random core_ready and occasional restarts
    ready_mode = 2;
    for (int m = 0; m < 20; m++) begin
      if ($urandom_range(0, 3) == 0) begin
        host(1, 0, 0, rnd_blk(), '0);
        repeat ($urandom_range(0, DEPTH - 1)) host(0, 1, 0, rnd_blk(), '0);
      end
      k = $urandom_range(1, DEPTH);
      q.delete();
      for (int i = 0; i < k; i++) q.push_back(rnd_blk());
      send_msg(q, {$urandom, $urandom, $urandom, $urandom}, 2);
      wait_digest();
      chk(bus.err == 1'b0, "rand_err", 128'(bus.err), 128'(0));
      chk(exp_cmd.size() == 0, "rand_drained", 128'(exp_cmd.size()), 128'(0));
      idle($urandom_range(0, 3));
    end

    ready_mode = 0;
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
